// File: rtl/ps2_pkg.sv
// Shared definitions for the buffered PS/2 receiver: FSM state encoding and
// the bit layout of an 11-bit PS/2 frame (start, 8 data LSB-first, parity, stop).
package ps2_pkg;

  // FSM state encoding, kept as plain constants for legacy tool compatibility.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DATA  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;

  // Frame layout as it sits in the receive shift register once complete.
  localparam int FRAME_LEN    = 11;
  localparam int BIT_START    = 0;
  localparam int BIT_DATA_LSB = 1;
  localparam int BIT_DATA_MSB = 8;
  localparam int BIT_PARITY   = 9;
  localparam int BIT_STOP     = 10;

  // Samples taken in DATA after the start bit: 8 data + parity + stop.
  localparam logic [3:0] DATA_SAMPLES = 4'(FRAME_LEN - 1);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. The head entry is visible on rd_data whenever
// the FIFO is non-empty (zero when empty). A write while full is accepted
// only if a read is accepted in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  // Accept/reject decisions and next pointer/occupancy values.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rd_ok    = rd_en && (count_q != '0);
    wr_ok    = wr_en && ((count_q != FULL_CNT) || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; empty masks stale contents and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 receiver with clock glitch filter, inter-edge timeout and byte FIFO.
// Optional feature: define PS2_RX_PARITY_CHECK_EN to enforce odd parity;
// without it the parity bit is sampled but ignored and parity_err is 0.
module ps2_rx_buffered #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rx_en,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  import ps2_pkg::*;

  localparam logic [19:0] TOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [1:0]            c_sync_q, c_sync_d;
  logic [1:0]            d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  f_clk_q, f_clk_d;
  logic                  fall_edge;
  logic                  ps2d_s;
  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0]  frame_q, frame_d;
  logic [19:0]           tout_q, tout_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  logic                  push_req;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic                  parity_err_q, parity_err_d;
`endif

  // Synchronisers, glitch filter and falling-edge detect on the filtered clock.
  always_comb begin
    c_sync_d = {c_sync_q[0], ps2c};
    d_sync_d = {d_sync_q[0], ps2d};
    filt_d   = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
    f_clk_d  = f_clk_q;
    if (&filt_q)       f_clk_d = 1'b1;
    else if (~|filt_q) f_clk_d = 1'b0;
    fall_edge = f_clk_q && !f_clk_d;
    ps2d_s    = d_sync_q[1];
  end

  // Frame FSM: start detect, LSB-first sampling, timeout and end-of-frame check.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    tout_d      = tout_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        tout_d = '0;
        // rx_en only gates the start; once in DATA the frame runs to completion.
        if (fall_edge && rx_en && !ps2d_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = DATA_SAMPLES;
          frame_d   = {ps2d_s, frame_q[FRAME_LEN-1:1]};
        end
      end
      ST_DATA: begin
        if (fall_edge) begin
          frame_d   = {ps2d_s, frame_q[FRAME_LEN-1:1]};
          bit_cnt_d = bit_cnt_q - 4'd1;
          tout_d    = '0;
          if (bit_cnt_q == 4'd1) state_d = ST_CHECK;
        end else if (tout_q == TOUT_LAST) begin
          // Stalled clock: drop the partial frame.
          frame_err_d = 1'b1;
          tout_d      = '0;
          state_d     = ST_IDLE;
        end else begin
          tout_d = tout_q + 20'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (!frame_q[BIT_STOP] || frame_q[BIT_START]) frame_err_d = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
        else if (!(^frame_q[BIT_PARITY:BIT_DATA_LSB])) parity_err_d = 1'b1;
`endif
        else push_req = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow: a set event wins over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (push_req && full && !rd_en) overflow_d = 1'b1;
    else if (err_clr)               overflow_d = 1'b0;
  end

  // All receiver state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q    <= '0;
      d_sync_q    <= '0;
      filt_q      <= '0;
      f_clk_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      tout_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      c_sync_q    <= c_sync_d;
      d_sync_q    <= d_sync_d;
      filt_q      <= filt_d;
      f_clk_q     <= f_clk_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      tout_q      <= tout_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  // Parity error pulse, aligned with frame_err.
  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_req),
    .wr_data (frame_q[BIT_DATA_MSB:BIT_DATA_LSB]),
    .rd_en   (rd_en),
    .rd_data (dout),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Scoreboard bench for ps2_rx_buffered: stimulus pushes expected bytes into a
// queue, a negedge monitor pops and compares whenever a pop is accepted.
module tb_ps2_rx_buffered;

  localparam int FILTER_LEN = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 2000;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam int PAR_PULSES = 1;
`else
  localparam int PAR_PULSES = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, ps2d, ps2c, rx_en, rd_en, err_clr;
  logic [7:0] dout;
  logic       empty, full, frame_err, parity_err, overflow;
  logic [$clog2(FIFO_DEPTH):0] count;

  int checks = 0;
  int failures = 0;
  int frame_err_cnt = 0;
  int parity_err_cnt = 0;
  logic [7:0] exp_q[$];

  ps2_rx_buffered #(
    .FILTER_LEN     (FILTER_LEN),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2d       (ps2d),
    .ps2c       (ps2c),
    .rx_en      (rx_en),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted pop against the scoreboard, count error pulses.
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h required no data", dout);
      end else begin
        check("pop_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    if (!reset && frame_err)  frame_err_cnt++;
    if (!reset && parity_err) parity_err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive nbits of a PS/2 frame: 10 cycles setup, 20 low, 10 high per bit.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit stop_bit,
                            input int nbits, input bit drop_rx, input bit pop_at_check);
    logic [10:0] bits;
    bits = {stop_bit, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      cycles(10);
      ps2c = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        // CHECK occupies the cycle FILTER_LEN+3 edges after ps2c falls.
        if (pop_at_check && i == 10) rd_en = (c == FILTER_LEN + 2);
      end
      ps2c = 1'b1;
      if (drop_rx && i == 0) rx_en = 1'b0;
      cycles(10);
    end
    ps2d = 1'b1;
    if (drop_rx) rx_en = 1'b1;
    cycles(10);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
    cycles(1);
  endtask

  initial begin
    reset = 1'b1; ps2d = 1'b1; ps2c = 1'b1; rx_en = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    cycles(5);
    reset = 1'b0;
    cycles(20);

    // Reset state
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);

    // Good frame 0x1C
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("good_dout", 32'(dout), 32'h1C);
    check("good_count", 32'(count), 32'd1);
    check("good_empty", 32'(empty), 32'h0);
    check("good_no_frame_err", 32'(frame_err_cnt), 32'd0);
    check("good_no_parity_err", 32'(parity_err_cnt), 32'd0);
    pop_one();
    check("good_popped_count", 32'(count), 32'd0);

    // Bad parity 0x1C
`ifdef PS2_RX_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    check("badpar_pulse", 32'(parity_err_cnt), 32'd1);
    check("badpar_count", 32'(count), 32'd0);
`else
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    check("badpar_ignored_count", 32'(count), 32'd1);
    check("badpar_tied_zero", 32'(parity_err_cnt), 32'd0);
    pop_one();
`endif

    // Abandoned frame -> timeout, then 0xF0
    send_frame(8'h3C, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    cycles(TIMEOUT + 100);
    check("timeout_frame_err", 32'(frame_err_cnt), 32'd1);
    check("timeout_count", 32'(count), 32'd0);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("after_timeout_dout", 32'(dout), 32'hF0);
    pop_one();

    // Stop bit 0 -> frame error, no push
    send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    check("stop0_frame_err", 32'(frame_err_cnt), 32'd2);
    check("stop0_count", 32'(count), 32'd0);

    // rx_en low blocks the start
    rx_en = 1'b0;
    send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    rx_en = 1'b1;
    check("rx_dis_count", 32'(count), 32'd0);

    // rx_en dropped mid-frame does not abort
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    check("rx_drop_count", 32'(count), 32'd1);
    pop_one();

    // Overflow: 0x01..0x05 into depth 4
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b0, 1'b1, 11, 1'b0, 1'b0);
    end
    check("ovf_full", 32'(full), 32'h1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'h1);
    for (int b = 0; b < 4; b++) pop_one();
    check("ovf_drained_empty", 32'(empty), 32'h1);
    check("ovf_sticky", 32'(overflow), 32'h1);
    pop_one();
    check("pop_empty_ignored", 32'(count), 32'd0);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    cycles(1);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Full FIFO, pop in the CHECK cycle of 0xAA
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("simul_pre_full", 32'(full), 32'h1);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    check("simul_count", 32'(count), 32'd4);
    check("simul_no_ovf", 32'(overflow), 32'h0);
    for (int b = 0; b < 4; b++) pop_one();
    check("simul_drained", 32'(empty), 32'h1);

    // Glitch shorter than the filter must not start a frame
    ps2d = 1'b0;
    ps2c = 1'b0;
    cycles(FILTER_LEN - 1);
    ps2c = 1'b1;
    ps2d = 1'b1;
    cycles(TIMEOUT + 100);
    check("glitch_no_timeout", 32'(frame_err_cnt), 32'd2);
    exp_q.push_back(8'h6B);
    send_frame(8'h6B, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("glitch_next_count", 32'(count), 32'd1);
    pop_one();

    // Reset mid-frame with data in the FIFO
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    cycles(3);
    reset = 1'b0;
    cycles(20);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'h1);
    check("midrst_dout", 32'(dout), 32'h0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("midrst_next_dout", 32'(dout), 32'h5A);
    pop_one();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("total_frame_err", 32'(frame_err_cnt), 32'd2);
    check("total_parity_err", 32'(parity_err_cnt), 32'(PAR_PULSES));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_buffered.md
PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

Interface
REQ-001 Parameter FILTER_LEN, default 8, SHALL set the ps2c glitch-filter length in clk cycles (legal range 2..16).
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the received-byte FIFO depth (power of two, 2..256).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the maximum clk cycles allowed between filtered falling edges inside a frame (legal range 1..2^20-1).
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ps2d, ps2c  input  1 each  raw asynchronous PS/2 data and clock lines.
REQ-007 rx_en  input  1  permits the start of a new frame.
REQ-008 rd_en  input  1  pops the FIFO head when empty=0.
REQ-009 err_clr  input  1  clears the sticky overflow flag.
REQ-010 dout  output  8  FIFO head byte (show-ahead).
REQ-011 empty, full  output  1 each  FIFO status flags.
REQ-012 count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 frame_err, parity_err  output  1 each  one-cycle error pulses.
REQ-014 overflow  output  1  sticky flag, set when a good byte is dropped.

Function
REQ-015 ps2c and ps2d SHALL each pass through a two-flop synchroniser before any other use.
REQ-016 Filter: synchronised ps2c SHALL shift into a FILTER_LEN-bit register.
- Filtered clock goes 1 when the register is all ones and 0 when it is all zeros; otherwise it holds.
- fall_edge is a one-cycle pulse on the 1->0 transition of the filtered clock.
REQ-017 FSM states SHALL be IDLE, DATA and CHECK.
REQ-018 IDLE->DATA SHALL occur on fall_edge & rx_en & ps2d==0 (start bit).
- fall_edge with ps2d==1 SHALL be ignored.
- Entering DATA loads a bit counter with 10.
REQ-019 DATA SHALL sample ps2d LSB-first on each fall_edge.
- The bit counter decrements on each sample.
- After the 10th sample (8 data bits, parity, stop) the FSM moves to CHECK.
REQ-020 Deasserting rx_en mid-frame SHALL NOT abort the frame; rx_en gates only the start.
REQ-021 Timeout: in DATA, a counter SHALL clear on every fall_edge and increment otherwise.
- On reaching TIMEOUT_CYCLES: pulse frame_err, discard the partial frame, return to IDLE.
REQ-022 CHECK SHALL last exactly one cycle, then return to IDLE.
- stop==0: pulse frame_err, no push.
- Else parity failure: pulse parity_err, no push.
- Else full==0: push the byte.
- Else full==1: drop the byte and set overflow.
REQ-023 A pushed byte SHALL appear on dout, with empty=0, the cycle after CHECK (latency 1 from the 11th fall_edge + 1).
REQ-024 Pop with empty=1 SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL both succeed with count unchanged, including when full=1.
- In that case no overflow is raised.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 overflow SHALL clear on err_clr.
- If err_clr and a new overflow event coincide, the flag SHALL remain set.

Reset
REQ-028 Reset SHALL:
- force state IDLE;
- clear the filter, synchronisers, bit and timeout counters and FIFO pointers;
- force dout=0, empty=1, full=0, count=0, frame_err=0, parity_err=0, overflow=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame.
- The first frame after release SHALL be received normally.

Configuration
REQ-030 With PS2_RX_PARITY_CHECK_EN defined, CHECK SHALL require odd parity over the 8 data bits plus the parity bit.
REQ-031 Without PS2_RX_PARITY_CHECK_EN, the parity bit SHALL be sampled but ignored, and parity_err SHALL be tied to 0.

Structure
REQ-032 Package ps2_pkg SHALL hold:
- the FSM state typedef;
- the frame length constant (11);
- bit-position constants (START=0, DATA 1..8, PARITY=9, STOP=10).
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo, parametrised by width and depth.

Verification
REQ-034 Frame 0x1C, parity 0, stop 1 -> dout=0x1C, count=1, no error pulses.
REQ-035 Frame 0x1C, parity 1 (macro defined) -> parity_err one pulse, count=0.
- Same frame with the macro undefined -> byte pushed.
REQ-036 Frame abandoned after 5 bits, idle TIMEOUT_CYCLES -> frame_err pulse.
- A following 0xF0 frame -> dout=0xF0.
REQ-037 FIFO_DEPTH=4, send 0x01..0x05 without popping:
- full=1, overflow=1, pops return 0x01..0x04;
- err_clr -> overflow=0.
REQ-038 full=1, rd_en asserted in the CHECK cycle of a good frame 0xAA -> count stays 4, overflow=0, 0xAA is popped last.
REQ-039 ps2c low glitch of FILTER_LEN-1 cycles -> no fall_edge, FSM stays IDLE.
- Reset asserted after bit 4 -> next frame 0x5A received intact.
